// File: rtl/dl_pkg.sv
// Shared definitions for the dl_* pipeline blocks: skid-buffer state encoding.
package dl_pkg;

  localparam int unsigned SKB_STATE_W = 2;

  typedef enum logic [SKB_STATE_W-1:0] {
    SKB_EMPTY = 2'd0,
    SKB_BUSY  = 2'd1,
    SKB_FULL  = 2'd2
  } skb_state_e;

endpackage

// File: rtl/dl_reg_en_arst.sv
// Parameterised enable register with asynchronous active-high reset.
module dl_reg_en_arst #(
  parameter int unsigned         W       = 32,
  parameter logic [W-1:0]        RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_o <= RST_VAL;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/dl_skid_buf.sv
// Two-entry valid/ready skid buffer with registered in_ready/out_valid.
// Optional synchronous flush input enabled by DL_SKID_BUF_FLUSH_EN.
module dl_skid_buf
  import dl_pkg::*;
#(
  parameter int unsigned          NUM_BITS = 32,
  parameter logic [NUM_BITS-1:0]  RST_VAL  = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_BITS-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUM_BITS-1:0] out_data
`ifdef DL_SKID_BUF_FLUSH_EN
  ,
  input  logic                flush
`endif
);

  skb_state_e          state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                in_fire, out_fire;
  logic                main_en, skid_en, main_from_skid;
  logic [NUM_BITS-1:0] main_d, skid_q;

  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid_q & out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;

  // State and handshake flops; handshakes are decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SKB_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      SKB_EMPTY: begin
        if (in_fire) begin
          main_en = 1'b1;
          state_d = SKB_BUSY;
        end
      end
      SKB_BUSY: begin
        if (in_fire && out_fire) begin
          main_en = 1'b1;
        end else if (in_fire) begin
          skid_en = 1'b1;
          state_d = SKB_FULL;
        end else if (out_fire) begin
          state_d = SKB_EMPTY;
        end
      end
      SKB_FULL: begin
        if (out_fire) begin
          main_en        = 1'b1;
          main_from_skid = 1'b1;
          state_d        = SKB_BUSY;
        end
      end
      default: state_d = SKB_EMPTY;
    endcase
`ifdef DL_SKID_BUF_FLUSH_EN
    // Flush empties the buffer but leaves both data registers untouched.
    if (flush) begin
      state_d        = SKB_EMPTY;
      main_en        = 1'b0;
      skid_en        = 1'b0;
      main_from_skid = 1'b0;
    end
`endif
  end

  always_comb begin
    in_ready_d  = (state_d != SKB_FULL);
    out_valid_d = (state_d != SKB_EMPTY);
    main_d      = main_from_skid ? skid_q : in_data;
  end

  dl_reg_en_arst #(.W(NUM_BITS), .RST_VAL(RST_VAL)) u_main (
    .clk  (clk),
    .rst  (rst),
    .en_i (main_en),
    .d_i  (main_d),
    .q_o  (out_data)
  );

  dl_reg_en_arst #(.W(NUM_BITS), .RST_VAL(RST_VAL)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .en_i (skid_en),
    .d_i  (in_data),
    .q_o  (skid_q)
  );

endmodule

// File: tb/tb_dl_skid_buf.sv
// Self-checking bench for dl_skid_buf: queue-based FIFO model plus directed cases.
// Define DL_SKID_BUF_FLUSH_EN to also exercise the flush input.
module tb_dl_skid_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
`ifdef DL_SKID_BUF_FLUSH_EN
  logic        flush = 1'b0;
`endif

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] mq[$];

  always #5 clk = ~clk;

  dl_skid_buf #(.NUM_BITS(32), .RST_VAL(32'h0)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef DL_SKID_BUF_FLUSH_EN
    ,
    .flush     (flush)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: at most two queued entries, head is what must be presented.
  always begin
    @(posedge clk or posedge rst);
    if (rst) begin
      mq.delete();
    end else begin
      automatic bit ov = (mq.size() > 0);
      automatic bit ir = (mq.size() < 2);
      automatic bit ifire = in_valid && ir;
      automatic bit ofire = ov && out_ready;
`ifdef DL_SKID_BUF_FLUSH_EN
      if (flush) begin
        mq.delete();
      end else
`endif
      begin
        if (ofire) void'(mq.pop_front());
        if (ifire) mq.push_back(in_data);
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
    if (mq.size() > 0) chk("out_data", out_data, mq[0]);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input logic v, input logic [31:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  initial begin
    // Reset with junk upstream
    send(1'b1, 32'hDEAD, 1'b1);
    repeat (3) begin
      tick();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_data", out_data, 32'd0);
    end
    send(1'b0, 32'hDEAD, 1'b1);
    rst = 1'b0;
    tick();
    chk("idle_out_valid", 32'(out_valid), 32'd0);

    // Streaming
    for (int i = 1; i <= 4; i++) begin
      send(1'b1, 32'(i), 1'b1);
      tick();
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_data", out_data, 32'(i));
      chk("stream_ready", 32'(in_ready), 32'd1);
    end
    send(1'b0, 32'd0, 1'b1);
    tick();
    chk("stream_end", 32'(out_valid), 32'd0);

    // Backpressure
    send(1'b1, 32'd10, 1'b0);
    tick();
    send(1'b1, 32'd11, 1'b0);
    tick();
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    send(1'b1, 32'd12, 1'b0);
    tick();
    chk("bp_hold_data", out_data, 32'd10);
    chk("bp_hold_ready", 32'(in_ready), 32'd0);
    send(1'b1, 32'd12, 1'b1);
    tick();
    chk("bp_out11", out_data, 32'd11);
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    tick();
    chk("bp_out12", out_data, 32'd12);
    send(1'b0, 32'd0, 1'b1);
    tick();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Drain from BUSY
    send(1'b1, 32'd5, 1'b0);
    tick();
    chk("drain_data", out_data, 32'd5);
    send(1'b0, 32'd0, 1'b1);
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_ready", 32'(in_ready), 32'd1);

    // Async reset while FULL
    send(1'b1, 32'd7, 1'b0);
    tick();
    send(1'b1, 32'd8, 1'b0);
    tick();
    chk("full78_ready", 32'(in_ready), 32'd0);
    send(1'b0, 32'd0, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    chk("arst_data", out_data, 32'd0);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      tick();
      chk("arst_no_replay", 32'(out_valid), 32'd0);
    end

`ifdef DL_SKID_BUF_FLUSH_EN
    send(1'b1, 32'd7, 1'b0);
    tick();
    send(1'b1, 32'd8, 1'b0);
    tick();
    send(1'b1, 32'd9, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_ready", 32'(in_ready), 32'd1);
    send(1'b0, 32'd0, 1'b1);
    repeat (2) begin
      tick();
      chk("flush_no_9", 32'(out_valid), 32'd0);
    end
`endif

    // Random traffic, checked by the per-cycle comparator
    for (int c = 0; c < 3000; c++) begin
      send(($urandom_range(0, 3) != 0), $urandom(), ($urandom_range(0, 2) != 0));
`ifdef DL_SKID_BUF_FLUSH_EN
      flush = ($urandom_range(0, 63) == 0);
`endif
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dl_skid_buf.md
Name: dl_skid_buf

Overview:
- Two-entry valid/ready skid buffer used as an elastic pipeline-stage register between core stages (e.g. fetch -> decode).
- Breaks the combinational ready path: in_ready is driven only from flops.
- Provides full throughput (one transfer per cycle) with no bubbles.
- Sits directly upstream of the plain enable-register stages and feeds them data plus a qualifying valid.

Parameters:
- NUM_BITS, 32, payload width in bits.
- RST_VAL, 0, reset value of the main and skid data registers (and hence out_data).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  buffer can accept a transfer (registered).
- in_data  input  NUM_BITS  upstream payload.
- out_valid  output  1  out_data is valid (registered).
- out_ready  input  1  downstream accepts.
- out_data  output  NUM_BITS  payload from the main register.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high on port rst.
- Fire conditions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Both are sampled at the rising edge of clk.
- Storage:
  - main register: drives out_data.
  - skid register: holds one overflow entry.
- States (2-bit encoding):
  - EMPTY: out_valid=0, in_ready=1.
  - BUSY: main full; out_valid=1, in_ready=1.
  - FULL: main and skid full; out_valid=1, in_ready=0.
- Transitions:
  - EMPTY, in_fire -> main<=in_data, BUSY. Otherwise stay.
  - BUSY, in_fire & out_fire -> main<=in_data, BUSY.
  - BUSY, in_fire & !out_fire -> skid<=in_data, FULL.
  - BUSY, !in_fire & out_fire -> EMPTY (main keeps its stale value).
  - BUSY, neither -> hold.
  - FULL, out_fire -> main<=skid, BUSY. in_valid is ignored (in_ready=0).
  - FULL, !out_fire -> hold.
- in_ready and out_valid are flop outputs decoded registered from the next state. No combinational path from out_ready to in_ready.
- Latency: in_fire at edge N -> out_valid=1 with that data after edge N; the transfer is earliest out_fire at edge N+1.
- Ordering: strict FIFO; payload is never dropped or duplicated.
- Reset:
  - While rst=1: state=EMPTY, out_valid=0, in_ready=1, main=skid=RST_VAL. All outputs are forced immediately (async).
  - Reset mid-transfer discards both entries.
  - Deassertion is synchronised externally.
- out_data is don't-care when out_valid=0. It must not change while out_valid=1 and out_ready=0.
- out_valid must not drop without out_fire.

Optional Feature:
- Macro DL_SKID_BUF_FLUSH_EN.
- With the macro defined:
  - Adds input port flush (1 bit, synchronous).
  - flush=1 at an edge -> state=EMPTY and out_valid=0 next cycle; any same-edge in_fire is discarded.
  - Data registers are unchanged. Flush has priority over all transitions; rst has priority over flush.
- Without the macro: no flush port; behaviour exactly as above.

Decomposition:
- Shared package dl_pkg:
  - state typedef/localparams SKB_EMPTY=2'd0, SKB_BUSY=2'd1, SKB_FULL=2'd2.
  - Encoding 2'd3 is illegal and recovers to SKB_EMPTY.
- One sub-module: dl_reg_en_arst, a parameterised enable register with async active-high reset. It is instantiated twice (main, skid).
- Control FSM stays in dl_skid_buf.

Test Plan:
- Reset/idle: assert rst with in_valid=1, in_data=32'hDEAD -> out_valid=0, in_ready=1, out_data=0 throughout; nothing captured after release.
- Streaming: out_ready=1, send 1,2,3,4 back to back -> out_data 1,2,3,4 on consecutive cycles, each one cycle after input; in_ready stays 1.
- Backpressure:
  - Send 10 with out_ready=0, then 11 -> in_ready=0 after second edge and 12 is held upstream.
  - Raise out_ready -> outputs 10, 11, 12 in order; nothing lost.
- Drain: BUSY holding 5, in_valid=0, out_ready=1 -> out_valid falls next cycle, state EMPTY.
- Async reset in FULL (entries 7, 8): pulse rst between edges -> out_valid=0 immediately, in_ready=1; 7 and 8 never appear.
- Flush (DL_SKID_BUF_FLUSH_EN): FULL, flush=1 with in_valid=1, in_data=9 -> EMPTY next cycle; 9 is not output.
